// File: rtl/voice_alloc_if.sv
// Event and voice-array signals between the event decoder, the allocator and the adsr bank.
// Build option: VOICE_STEAL_EN in voice_alloc only; the bundle itself is configuration-free.
interface voice_alloc_if #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7
);
    logic                         ev_valid;
    logic                         ev_ready;
    logic                         ev_on;
    logic [NOTE_W-1:0]            ev_note;
    logic [NUM_VOICES-1:0]        voice_idle;
    logic [NUM_VOICES-1:0]        voice_trig;
    logic [NUM_VOICES*NOTE_W-1:0] voice_note;
    logic                         ev_drop;

    modport master (
        output ev_valid, ev_on, ev_note, voice_idle,
        input  ev_ready, voice_trig, voice_note, ev_drop
    );

    modport slave (
        input  ev_valid, ev_on, ev_note, voice_idle,
        output ev_ready, voice_trig, voice_note, ev_drop
    );
endinterface

// File: rtl/voice_alloc.sv
// Polyphony allocator: binds note-on/off events to NUM_VOICES adsr voices (optional VOICE_STEAL_EN).
// Latency: result on voice_trig/voice_note/ev_drop 2 edges after accept (IDLE->EXEC->IDLE).
// Backpressure: ev_ready is low for the EXEC cycle, so at most one event per 2 cycles.
module voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7
) (
    input  logic          clk,
    input  logic          rst,
    voice_alloc_if.slave  bus
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic       {S_IDLE, S_EXEC} state_t;
    typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vstate_t;

    state_t              r_state, w_state_nxt;
    logic                r_ev_ready, w_ready_nxt;
    logic                r_ev_on;
    logic [NOTE_W-1:0]   r_ev_note;
    logic                r_drop, w_drop_nxt;
    logic [NUM_VOICES-1:0] r_trig;

    vstate_t             r_vs       [NUM_VOICES];
    vstate_t             w_vs_nxt   [NUM_VOICES];
    logic [1:0]          r_guard    [NUM_VOICES];
    logic [1:0]          w_guard_nxt[NUM_VOICES];
    logic [NOTE_W-1:0]   r_note     [NUM_VOICES];
    logic [NOTE_W-1:0]   w_note_nxt [NUM_VOICES];

    logic                w_accept;
    logic                w_match;
    logic [IDX_W-1:0]    w_match_idx;
    logic                w_has_free;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_alloc;
    logic [IDX_W-1:0]    w_tgt;

`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0]    r_age      [NUM_VOICES];
    logic [IDX_W-1:0]    w_age_nxt  [NUM_VOICES];
    logic                w_has_held;
    logic [IDX_W-1:0]    w_steal_idx;
    logic [IDX_W-1:0]    w_best_age;
    logic                w_tgt_held;
`endif

    assign w_accept = bus.ev_valid && r_ev_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // Candidate search: descending loop so the lowest index wins.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_has_free  = 1'b0;
        w_free_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_vs[v] == V_HELD && r_note[v] == r_ev_note) begin
                w_match     = 1'b1;
                w_match_idx = IDX_W'(v);
            end
            if (r_vs[v] == V_FREE) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(v);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Oldest held voice; strict compare keeps the lowest index on a tie.
    always_comb begin
        w_has_held  = 1'b0;
        w_steal_idx = '0;
        w_best_age  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_vs[v] == V_HELD && (!w_has_held || r_age[v] > w_best_age)) begin
                w_has_held  = 1'b1;
                w_steal_idx = IDX_W'(v);
                w_best_age  = r_age[v];
            end
        end
    end
`endif

    always_comb begin
        w_drop_nxt = 1'b0;
        w_alloc    = 1'b0;
        w_tgt      = '0;
`ifdef VOICE_STEAL_EN
        w_tgt_held = 1'b0;
`endif
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_vs_nxt[v]    = r_vs[v];
            w_guard_nxt[v] = r_guard[v];
            w_note_nxt[v]  = r_note[v];
            // Guard covers the adsr's lag before voice_idle reflects the release.
            if (r_vs[v] == V_REL) begin
                if (r_guard[v] != 2'd0)     w_guard_nxt[v] = r_guard[v] - 2'd1;
                else if (bus.voice_idle[v]) w_vs_nxt[v]    = V_FREE;
            end
        end

        if (r_state == S_EXEC) begin
            if (r_ev_on) begin
                if (w_match) begin
                    w_alloc = 1'b0;
                end else if (w_has_free) begin
                    w_alloc = 1'b1;
                    w_tgt   = w_free_idx;
`ifdef VOICE_STEAL_EN
                end else if (w_has_held) begin
                    w_alloc    = 1'b1;
                    w_tgt      = w_steal_idx;
                    w_tgt_held = 1'b1;
`endif
                end else begin
                    w_drop_nxt = 1'b1;
                end
            end else if (w_match) begin
                w_vs_nxt[w_match_idx]    = V_REL;
                w_guard_nxt[w_match_idx] = 2'd2;
            end
            if (w_alloc) begin
                w_vs_nxt[w_tgt]   = V_HELD;
                w_note_nxt[w_tgt] = r_ev_note;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    always_comb begin
        for (int u = 0; u < NUM_VOICES; u++) begin
            w_age_nxt[u] = r_age[u];
            if (w_alloc) begin
                if (IDX_W'(u) == w_tgt) begin
                    w_age_nxt[u] = '0;
                end else if (r_vs[u] == V_HELD && (!w_tgt_held || r_age[u] < r_age[w_tgt])
                             && r_age[u] != IDX_W'(NUM_VOICES - 1)) begin
                    w_age_nxt[u] = r_age[u] + 1'b1;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ev_ready <= 1'b1;
            r_ev_on    <= 1'b0;
            r_ev_note  <= '0;
            r_drop     <= 1'b0;
            r_trig     <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_vs[v]    <= V_FREE;
                r_guard[v] <= 2'd0;
                r_note[v]  <= '0;
`ifdef VOICE_STEAL_EN
                r_age[v]   <= '0;
`endif
            end
        end else begin
            r_ev_ready <= w_ready_nxt;
            r_drop     <= w_drop_nxt;
            if (w_accept) begin
                r_ev_on   <= bus.ev_on;
                r_ev_note <= bus.ev_note;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_vs[v]    <= w_vs_nxt[v];
                r_guard[v] <= w_guard_nxt[v];
                r_note[v]  <= w_note_nxt[v];
                r_trig[v]  <= (w_vs_nxt[v] == V_HELD);
`ifdef VOICE_STEAL_EN
                r_age[v]   <= w_age_nxt[v];
`endif
            end
        end
    end

    assign bus.ev_ready   = r_ev_ready;
    assign bus.ev_drop    = r_drop;
    assign bus.voice_trig = r_trig;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
        assign bus.voice_note[g*NOTE_W +: NOTE_W] = r_note[g];
    end
endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc; expectations follow VOICE_STEAL_EN when it is defined.
module tb_voice_alloc;
    localparam int NV = 4;
    localparam int NW = 7;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n0, n1;

    voice_alloc_if #(.NUM_VOICES(NV), .NOTE_W(NW)) bus ();

    voice_alloc #(.NUM_VOICES(NV), .NOTE_W(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
        return {4'b0, d[6:0], c[6:0], b[6:0], a[6:0]};
    endfunction

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic send(input logic on, input int note);
        int k;
        k = 0;
        while (!bus.ev_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.ev_ready) check_eq("rdy_timeout", 32'd0, 32'd1);
        bus.ev_valid = 1'b1;
        bus.ev_on    = on;
        bus.ev_note  = note[6:0];
        @(negedge clk);
        bus.ev_valid = 1'b0;
        bus.ev_on    = ~on;
        bus.ev_note  = '0;
        check_eq("rdy_lo", bus.ev_ready, 32'd0);
        @(negedge clk);
        check_eq("rdy_hi", bus.ev_ready, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.ev_valid   = 1'b0;
        bus.ev_on      = 1'b0;
        bus.ev_note    = '0;
        bus.voice_idle = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_trig", bus.voice_trig, 32'd0);
        check_eq("rst_note", bus.voice_note, 32'd0);
        check_eq("rst_rdy",  bus.ev_ready,   32'd1);
        check_eq("rst_drop", bus.ev_drop,    32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_trig", bus.voice_trig, 32'd0);

        send(1'b1, 60);
        check_eq("on60_trig", bus.voice_trig, 32'h1);
        check_eq("on60_note", bus.voice_note, pack(60, 0, 0, 0));
        check_eq("on60_drop", bus.ev_drop,    32'd0);
        send(1'b1, 64);
        check_eq("on64_trig", bus.voice_trig, 32'h3);
        check_eq("on64_note", bus.voice_note, pack(60, 64, 0, 0));

        send(1'b0, 60);
        check_eq("off60_trig", bus.voice_trig, 32'h2);
        check_eq("off60_note", bus.voice_note, pack(60, 64, 0, 0));
        bus.voice_idle = '1;
        repeat (5) @(negedge clk);
        check_eq("idle_held_trig", bus.voice_trig, 32'h2);
        send(1'b1, 67);
        check_eq("reuse_trig", bus.voice_trig, 32'h3);
        check_eq("reuse_note", bus.voice_note, pack(67, 64, 0, 0));
        bus.voice_idle = '0;

        // Reset while an event is in EXEC
        bus.ev_valid = 1'b1;
        bus.ev_on    = 1'b1;
        bus.ev_note  = 7'd70;
        @(negedge clk);
        bus.ev_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_trig", bus.voice_trig, 32'd0);
        check_eq("mid_rst_note", bus.voice_note, 32'd0);
        check_eq("mid_rst_rdy",  bus.ev_ready,   32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_rst_lost_trig", bus.voice_trig, 32'd0);
        check_eq("mid_rst_lost_drop", bus.ev_drop,    32'd0);

        send(1'b1, 60);
        send(1'b1, 62);
        send(1'b1, 64);
        send(1'b1, 65);
        check_eq("full_trig", bus.voice_trig, 32'hf);
        check_eq("full_note", bus.voice_note, pack(60, 62, 64, 65));

        send(1'b1, 67);
`ifdef VOICE_STEAL_EN
        n0 = 67;
        check_eq("steal_drop", bus.ev_drop, 32'd0);
`else
        n0 = 60;
        check_eq("nosteal_drop", bus.ev_drop, 32'd1);
`endif
        check_eq("over_trig", bus.voice_trig, 32'hf);
        check_eq("over_note", bus.voice_note, pack(n0, 62, 64, 65));
        @(negedge clk);
        check_eq("drop_pulse_end", bus.ev_drop, 32'd0);

        n1 = 62;
`ifdef VOICE_STEAL_EN
        send(1'b1, 69);
        n1 = 69;
        check_eq("steal2_note", bus.voice_note, pack(n0, n1, 64, 65));
        check_eq("steal2_trig", bus.voice_trig, 32'hf);
`endif

        send(1'b0, 50);
        check_eq("off_miss_trig", bus.voice_trig, 32'hf);
        check_eq("off_miss_note", bus.voice_note, pack(n0, n1, 64, 65));
        send(1'b1, 64);
        check_eq("dup_trig", bus.voice_trig, 32'hf);
        check_eq("dup_note", bus.voice_note, pack(n0, n1, 64, 65));
        check_eq("dup_drop", bus.ev_drop,    32'd0);

        send(1'b0, n0);
        check_eq("rel0_trig", bus.voice_trig, 32'he);
        send(1'b0, n1);
        send(1'b0, 64);
        send(1'b0, 65);
        check_eq("rel_all_trig", bus.voice_trig, 32'h0);
        repeat (5) @(negedge clk);
        send(1'b1, 70);
        check_eq("allrel_drop", bus.ev_drop,    32'd1);
        check_eq("allrel_trig", bus.voice_trig, 32'h0);
        check_eq("allrel_note", bus.voice_note, pack(n0, n1, 64, 65));

        bus.voice_idle = '1;
        repeat (5) @(negedge clk);
        send(1'b1, 70);
        check_eq("freed_trig", bus.voice_trig, 32'h1);
        check_eq("freed_note", bus.voice_note, pack(70, n1, 64, 65));
        check_eq("freed_drop", bus.ev_drop,    32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
